// File: rtl/phase_meas_pkg.sv
// Shared state encoding and default parameters for the phase measurement sequencer.
package phase_meas_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ARM,
        WAIT_A,
        WAIT_B,
        SETTLE,
        SAMPLE,
        FINISH
    } phase_meas_state_t;

    localparam int DEF_WIDTH         = 64;
    localparam int DEF_AVG_LOG2      = 2;
    localparam int DEF_TIMEOUT       = 50_000_000;
    localparam int DEF_CLR_CYCLES    = 4;
    localparam int DEF_SETTLE_CYCLES = 8;
    localparam int DEF_SYNC_STAGES   = 2;

endpackage

// File: rtl/phase_measure_ctrl_edge_sync.sv
// Multi-flop synchronizer for an asynchronous channel followed by a registered
// one-cycle rising-edge pulse; latency from raw edge to pulse is SYNC_STAGES+1.
module edge_sync
    import phase_meas_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic sysClk,
    input  logic sysRst,
    input  logic din,
    output logic edgePulse
);

    logic [SYNC_STAGES-1:0] syncPipe;
    logic                   prevQ;

    // Flops reset low so a channel idling low cannot fake an edge after reset.
    always_ff @(posedge sysClk or posedge sysRst) begin
        if (sysRst) begin
            syncPipe  <= '0;
            prevQ     <= 1'b0;
            edgePulse <= 1'b0;
        end else begin
            syncPipe  <= {syncPipe[SYNC_STAGES-2:0], din};
            prevQ     <= syncPipe[SYNC_STAGES-1];
            edgePulse <= syncPipe[SYNC_STAGES-1] & ~prevQ;
        end
    end

endmodule

// File: rtl/phase_measure_ctrl.sv
// Sequencer for the two-channel phase detector: owns detector reset, collects
// 2^AVG_LOG2 CHA->CHB samples of diffCounter and publishes the truncated mean.
module phase_measure_ctrl
    import phase_meas_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int AVG_LOG2      = DEF_AVG_LOG2,
    parameter int TIMEOUT       = DEF_TIMEOUT,
    parameter int CLR_CYCLES    = DEF_CLR_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
    input  logic             sysClk,
    input  logic             sysRst,
    input  logic             start,
    input  logic             abort,
    input  logic             CHA,
    input  logic             CHB,
    input  logic [WIDTH-1:0] diffCounter,
    output logic             detRst,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [WIDTH-1:0] phaseAvg
);

    localparam int ACC_W = WIDTH + AVG_LOG2;
    localparam int IDX_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'((1 << AVG_LOG2) - 1);
    localparam logic [31:0]      TO_LOAD   = 32'(TIMEOUT);
    localparam logic [31:0]      CLR_LOAD  = 32'(CLR_CYCLES - 1);
    localparam logic [31:0]      SETL_LOAD = 32'(SETTLE_CYCLES - 1);

    phase_meas_state_t state;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  accSum;
    logic [IDX_W-1:0]  idx;
    logic [31:0]       cnt;
    logic              chaEdge;
    logic              chbEdge;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) uSyncA (
        .sysClk    (sysClk),
        .sysRst    (sysRst),
        .din       (CHA),
        .edgePulse (chaEdge)
    );

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) uSyncB (
        .sysClk    (sysClk),
        .sysRst    (sysRst),
        .din       (CHB),
        .edgePulse (chbEdge)
    );

    assign accSum = acc + ACC_W'(diffCounter);

    // Outputs are registered alongside the state; done and phaseAvg are
    // loaded on the SAMPLE->FINISH step so they appear in the FINISH cycle.
    always_ff @(posedge sysClk or posedge sysRst) begin
        if (sysRst) begin
            state    <= IDLE;
            detRst   <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            timeout  <= 1'b0;
            phaseAvg <= '0;
            acc      <= '0;
            idx      <= '0;
            cnt      <= '0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && abort) begin
                state  <= IDLE;
                busy   <= 1'b0;
                detRst <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            state   <= CLEAR;
                            busy    <= 1'b1;
                            detRst  <= 1'b1;
                            acc     <= '0;
                            idx     <= '0;
                            timeout <= 1'b0;
                            cnt     <= CLR_LOAD;
                        end
                    end
                    CLEAR: begin
                        if (cnt == 32'd0) begin
                            state  <= ARM;
                            detRst <= 1'b0;
                        end else begin
                            cnt <= cnt - 32'd1;
                        end
                    end
                    ARM: begin
                        state <= WAIT_A;
                        cnt   <= TO_LOAD;
                    end
                    WAIT_A: begin
                        if (chaEdge) begin
                            state <= WAIT_B;
                            cnt   <= TO_LOAD;
                        end else if (cnt <= 32'd1) begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            detRst  <= 1'b1;
                            timeout <= 1'b1;
                        end else begin
                            cnt <= cnt - 32'd1;
                        end
                    end
                    WAIT_B: begin
                        if (chbEdge) begin
                            state <= SETTLE;
                            cnt   <= SETL_LOAD;
                        end else if (cnt <= 32'd1) begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            detRst  <= 1'b1;
                            timeout <= 1'b1;
                        end else begin
                            cnt <= cnt - 32'd1;
                        end
                    end
                    SETTLE: begin
                        if (cnt == 32'd0) begin
                            state <= SAMPLE;
                        end else begin
                            cnt <= cnt - 32'd1;
                        end
                    end
                    SAMPLE: begin
                        acc <= accSum;
                        if (idx == LAST_IDX) begin
                            state    <= FINISH;
                            detRst   <= 1'b1;
                            phaseAvg <= accSum[ACC_W-1:AVG_LOG2];
                            done     <= 1'b1;
                        end else begin
                            state <= WAIT_A;
                            idx   <= idx + IDX_W'(1);
                            cnt   <= TO_LOAD;
                        end
                    end
                    FINISH: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        detRst <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_phase_measure_ctrl.sv
// Directed bench for phase_measure_ctrl; expected averages are queued as
// samples are driven and compared whenever done pulses.
module tb_phase_measure_ctrl;

    localparam int W   = 64;
    localparam int AL  = 2;
    localparam int TO  = 1000;
    localparam int CLR = 4;
    localparam int SET = 8;
    localparam int SYN = 2;

    logic         sysClk = 1'b0;
    logic         sysRst;
    logic         start;
    logic         abort;
    logic         CHA;
    logic         CHB;
    logic [W-1:0] diffCounter;
    logic         detRst;
    logic         busy;
    logic         done;
    logic         timeout;
    logic [W-1:0] phaseAvg;

    int checks    = 0;
    int errors    = 0;
    int doneCount = 0;
    int expDone   = 0;
    logic [W-1:0] expQ[$];
    logic [W-1:0] allOnes;

    always #5 sysClk = ~sysClk;

    phase_measure_ctrl #(
        .WIDTH(W), .AVG_LOG2(AL), .TIMEOUT(TO),
        .CLR_CYCLES(CLR), .SETTLE_CYCLES(SET), .SYNC_STAGES(SYN)
    ) dut (
        .sysClk      (sysClk),
        .sysRst      (sysRst),
        .start       (start),
        .abort       (abort),
        .CHA         (CHA),
        .CHB         (CHB),
        .diffCounter (diffCounter),
        .detRst      (detRst),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .phaseAvg    (phaseAvg)
    );

    task automatic checkVal(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysClk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic pushAvg(input logic [W-1:0] v);
        expQ.push_back(v);
        expDone++;
    endtask

    task automatic doStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic doSample(input logic [W-1:0] v);
        diffCounter = v;
        CHA = 1'b1;
        ticks(5);
        CHA = 1'b0;
        ticks(2);
        CHB = 1'b1;
        ticks(5);
        CHB = 1'b0;
        ticks(20);
    endtask

    // Scoreboard: every done must match the oldest queued average.
    always @(negedge sysClk) begin
        if (!sysRst && done) begin
            doneCount++;
            checkBit("done_expected", expQ.size() != 0, 1'b1);
            if (expQ.size() != 0) begin
                checkVal("phaseAvg", phaseAvg, expQ.pop_front());
                checkBit("busy_at_done", busy, 1'b1);
            end
        end
    end

    initial begin
        allOnes     = '1;
        sysRst      = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        CHA         = 1'b0;
        CHB         = 1'b0;
        diffCounter = '0;
        ticks(3);
        checkBit("rst_detRst", detRst, 1'b1);
        checkBit("rst_busy", busy, 1'b0);
        checkBit("rst_done", done, 1'b0);
        checkBit("rst_timeout", timeout, 1'b0);
        checkVal("rst_phaseAvg", phaseAvg, 64'd0);
        sysRst = 1'b0;
        ticks(2);

        // start and abort together: abort wins
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        checkBit("start_abort_idle", busy, 1'b0);

        // nominal 100,102,98,104 -> 101, with exact CLEAR/ARM and done timing
        doStart();
        checkBit("busy_rise", busy, 1'b1);
        ticks(CLR - 1);
        checkBit("detRst_clear", detRst, 1'b1);
        tick();
        checkBit("detRst_arm", detRst, 1'b0);
        ticks(2);
        pushAvg(64'd101);
        doSample(64'd100);
        doSample(64'd102);
        doSample(64'd98);
        diffCounter = 64'd104;
        CHA = 1'b1;
        ticks(5);
        CHA = 1'b0;
        ticks(2);
        CHB = 1'b1;
        ticks(SYN + SET + 2);
        checkBit("done_not_early", done, 1'b0);
        tick();
        checkBit("done_on_time", done, 1'b1);
        tick();
        checkBit("busy_fall", busy, 1'b0);
        CHB = 1'b0;
        ticks(5);
        checkVal("nominal_doneCount", 64'(doneCount), 64'(expDone));
        checkBit("nominal_timeout", timeout, 1'b0);

        // truncation 5,6,5,6 -> 22/4 = 5
        doStart();
        ticks(8);
        pushAvg(64'd5);
        doSample(64'd5);
        doSample(64'd6);
        doSample(64'd5);
        doSample(64'd6);

        // full-scale samples must not overflow the accumulator
        doStart();
        ticks(8);
        pushAvg(allOnes);
        repeat (4) doSample(allOnes);
        checkVal("fullscale_doneCount", 64'(doneCount), 64'(expDone));

        // timeout: CHA only, fires TO cycles after WAIT_B entry
        doStart();
        ticks(8);
        CHA = 1'b1;
        ticks(5);
        CHA = 1'b0;
        ticks(TO - 2);
        checkBit("timeout_not_early", timeout, 1'b0);
        checkBit("timeout_busy_before", busy, 1'b1);
        tick();
        checkBit("timeout_set", timeout, 1'b1);
        checkBit("timeout_idle", busy, 1'b0);
        checkBit("timeout_detRst", detRst, 1'b1);
        checkVal("timeout_phaseAvg_hold", phaseAvg, allOnes);
        checkVal("timeout_doneCount", 64'(doneCount), 64'(expDone));
        doStart();
        checkBit("timeout_cleared_by_start", timeout, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // abort during sample 2; following run ignores discarded data
        doStart();
        ticks(8);
        doSample(64'd100);
        diffCounter = 64'd999;
        CHA = 1'b1;
        ticks(5);
        CHA = 1'b0;
        ticks(2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkBit("abort_idle", busy, 1'b0);
        checkBit("abort_detRst", detRst, 1'b1);
        ticks(20);
        checkVal("abort_doneCount", 64'(doneCount), 64'(expDone));
        doStart();
        ticks(8);
        pushAvg(64'd25);
        doSample(64'd10);
        doSample(64'd20);
        doSample(64'd30);
        doSample(64'd40);

        // CHA and CHB together: B not consumed, next CHB takes the sample
        doStart();
        ticks(8);
        diffCounter = 64'd1000;
        CHA = 1'b1;
        CHB = 1'b1;
        ticks(5);
        CHA = 1'b0;
        CHB = 1'b0;
        ticks(20);
        checkBit("simul_still_busy", busy, 1'b1);
        pushAvg(64'd40);
        repeat (4) doSample(64'd40);
        checkVal("simul_doneCount", 64'(doneCount), 64'(expDone));

        // start while busy is ignored
        doStart();
        ticks(8);
        pushAvg(64'd8);
        doSample(64'd7);
        start = 1'b1;
        tick();
        start = 1'b0;
        doSample(64'd8);
        start = 1'b1;
        ticks(3);
        start = 1'b0;
        doSample(64'd9);
        doSample(64'd10);
        ticks(10);
        checkVal("busy_start_doneCount", 64'(doneCount), 64'(expDone));
        checkBit("busy_start_idle", busy, 1'b0);

        // asynchronous reset mid-WAIT_B
        doStart();
        ticks(8);
        CHA = 1'b1;
        ticks(5);
        CHA = 1'b0;
        ticks(3);
        #2 sysRst = 1'b1;
        #1;
        checkBit("midrst_detRst", detRst, 1'b1);
        checkBit("midrst_busy", busy, 1'b0);
        checkBit("midrst_done", done, 1'b0);
        checkBit("midrst_timeout", timeout, 1'b0);
        checkVal("midrst_phaseAvg", phaseAvg, 64'd0);
        ticks(3);
        sysRst = 1'b0;
        ticks(20);
        checkBit("postrst_idle", busy, 1'b0);
        checkBit("postrst_detRst", detRst, 1'b1);
        checkVal("postrst_doneCount", 64'(doneCount), 64'(expDone));
        checkVal("queue_drained", 64'(expQ.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
